// File: rtl/ucie_ctl_phy_sb_pkg.sv
// Shared types and helpers for the UCIe PHY sideband transmit path.
package ucie_ctl_phy_sb_pkg;

  // Message assembly state: IDLE means beat count 0, COLLECT means a partial message is held.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_e;

  localparam int SB_W_DEFAULT = 64;

  // Number of adapter beats that make up one sideband message.
  function automatic int calc_beats(input int sb_w, input int nc);
    return sb_w / nc;
  endfunction

  // Width of the beat counter; at least one bit even when a message is one beat.
  function automatic int calc_beat_cnt_w(input int sb_w, input int nc);
    int beats;
    beats = sb_w / nc;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head output.
// A push while full is accepted only if a pop happens in the same cycle.
module ucie_ctl_sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers; storage clears so the head reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ucie_ctl_phy_sb_msg_tx_fifo.sv
// Sideband transmit path: assembles NC-bit adapter beats into SB_W-bit messages,
// queues them for the serializer and returns one credit per drained message.
//
// Handshakes: the adapter side has no ready; a beat is taken every cycle
// i_rdi_lp_cfg_valid is high and flow control is by credits. Toward the
// serializer, a message transfers on a cycle with o_sb_data_valid && i_sb_data_ready;
// once valid is high, valid and data hold until that transfer.
module ucie_ctl_phy_sb_msg_tx_fifo
  import ucie_ctl_phy_sb_pkg::*;
#(
  parameter int NC    = 32,
  parameter int SB_W  = SB_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rdi_lp_cfg_valid,
  input  logic [NC-1:0]   i_rdi_lp_cfg,
  output logic            o_rdi_pl_cfg_crd,
  output logic            o_sb_data_valid,
  output logic [SB_W-1:0] o_data_sent_sb,
  input  logic            i_sb_data_ready,
  output logic            o_overflow_err,
  output logic            o_dbg_asm_state
);

  localparam int BEATS = calc_beats(SB_W, NC);
  localparam int CNT_W = calc_beat_cnt_w(SB_W, NC);
  localparam int PW    = $clog2(DEPTH + 1);

  asm_state_e      state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SB_W-1:0]  partial_q, partial_d;
  logic [SB_W-1:0]  asm_word;
  logic             last_beat;
  logic             push;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  logic [PW-1:0]    pending_q, pending_d;
  logic             crd_q, crd_d;
  logic             issue;
  logic             err_q, err_d;
  int               pend_calc;

  assign o_dbg_asm_state = state_q;
  assign last_beat       = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign o_sb_data_valid = !fifo_empty;
  assign pop             = o_sb_data_valid && i_sb_data_ready;

  // Merge the current beat into the partial word at its slot.
  always_comb begin
    asm_word = partial_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt_q == CNT_W'(k)) asm_word[k*NC +: NC] = i_rdi_lp_cfg;
    end
  end

  // Assembly FSM next state: count beats, push the complete word on the last one.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    partial_d  = partial_q;
    push       = 1'b0;
    if (i_rdi_lp_cfg_valid) begin
      if (last_beat) begin
        push       = 1'b1;
        beat_cnt_d = '0;
        partial_d  = '0;
        state_d    = IDLE;
      end else begin
        partial_d  = asm_word;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        state_d    = COLLECT;
      end
    end
  end

  // Assembly FSM registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      partial_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      partial_q  <= partial_d;
    end
  end

  ucie_ctl_sync_fifo #(
    .W     (SB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (asm_word),
    .i_pop   (pop),
    .o_rdata (o_data_sent_sb),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Credit bookkeeping and sticky overflow: a pulse goes out whenever credits are pending.
  always_comb begin
    issue     = (pending_q != '0);
    crd_d     = issue;
    pend_calc = int'(pending_q) + (pop ? 1 : 0) - (issue ? 1 : 0);
    if (pend_calc > DEPTH) pend_calc = DEPTH;
    pending_d = PW'(pend_calc);
    err_d     = err_q || (push && fifo_full && !pop);
  end

  // Credit and error registers; credits re-initialise to a full FIFO's worth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= PW'(DEPTH);
      crd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      crd_q     <= crd_d;
      err_q     <= err_d;
    end
  end

  assign o_rdi_pl_cfg_crd = crd_q;
  assign o_overflow_err   = err_q;

endmodule

// File: tb/tb_ucie_ctl_phy_sb_msg_tx_fifo.sv
// Directed bench for the sideband transmit FIFO at NC=32, SB_W=64, DEPTH=4.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_ucie_ctl_phy_sb_msg_tx_fifo;
  import ucie_ctl_phy_sb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        lp_valid;
  logic [31:0] lp_cfg;
  logic        crd;
  logic        sb_valid;
  logic [63:0] sb_data;
  logic        sb_ready;
  logic        ovf;
  logic        dbg_state;

  int total;
  int bad;

  logic [63:0] exp_q[$];

  ucie_ctl_phy_sb_msg_tx_fifo #(
    .NC    (32),
    .SB_W  (64),
    .DEPTH (4)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rdi_lp_cfg_valid (lp_valid),
    .i_rdi_lp_cfg       (lp_cfg),
    .o_rdi_pl_cfg_crd   (crd),
    .o_sb_data_valid    (sb_valid),
    .o_data_sent_sb     (sb_data),
    .i_sb_data_ready    (sb_ready),
    .o_overflow_err     (ovf),
    .o_dbg_asm_state    (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  // Driver: present one beat for one cycle.
  task automatic send_beat(input logic [31:0] d);
    lp_valid = 1'b1;
    lp_cfg   = d;
    cycle();
    lp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    total++; if (crd !== 1'b0) begin bad++; $display("FAIL rst_crd got=%b exp=0", crd); end
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", sb_valid); end
    total++; if (sb_data !== 64'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", sb_data); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%b exp=%b", dbg_state, IDLE); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      total++;
      if (crd !== (i < 4)) begin
        bad++; $display("FAIL init_crd cycle=%0d got=%b exp=%b", i, crd, (i < 4));
      end
    end
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", sb_valid); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL idle_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_two_beats();
    sb_ready = 1'b0;
    send_beat(32'hAAAA_0001);
    total++; if (dbg_state !== COLLECT) begin bad++; $display("FAIL tb_state got=%b exp=%b", dbg_state, COLLECT); end
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL tb_early_valid got=%b exp=0", sb_valid); end
    send_beat(32'hBBBB_0002);
    total++; if (sb_valid !== 1'b1) begin bad++; $display("FAIL tb_valid got=%b exp=1", sb_valid); end
    total++; if (sb_data !== 64'hBBBB_0002_AAAA_0001) begin bad++; $display("FAIL tb_data got=%h exp=%h", sb_data, 64'hBBBB_0002_AAAA_0001); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL tb_state_idle got=%b exp=%b", dbg_state, IDLE); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (sb_valid !== 1'b1 || sb_data !== 64'hBBBB_0002_AAAA_0001) begin
        bad++; $display("FAIL tb_hold got=%b/%h exp=1/%h", sb_valid, sb_data, 64'hBBBB_0002_AAAA_0001);
      end
    end
    sb_ready = 1'b1;
    cycle();
    sb_ready = 1'b0;
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL tb_pop_valid got=%b exp=0", sb_valid); end
    total++; if (crd !== 1'b0) begin bad++; $display("FAIL tb_crd_early got=%b exp=0", crd); end
    cycle();
    total++; if (crd !== 1'b1) begin bad++; $display("FAIL tb_crd_pulse got=%b exp=1", crd); end
    cycle();
    total++; if (crd !== 1'b0) begin bad++; $display("FAIL tb_crd_after got=%b exp=0", crd); end
  endtask

  task automatic test_gap();
    sb_ready = 1'b0;
    send_beat(32'h0000_0001);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (sb_valid !== 1'b0 || dbg_state !== COLLECT) begin
        bad++; $display("FAIL gap_hold got=%b/%b exp=0/%b", sb_valid, dbg_state, COLLECT);
      end
    end
    send_beat(32'h0000_0002);
    total++; if (sb_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b exp=1", sb_valid); end
    total++; if (sb_data !== 64'h0000_0002_0000_0001) begin bad++; $display("FAIL gap_data got=%h exp=%h", sb_data, 64'h0000_0002_0000_0001); end
    sb_ready = 1'b1;
    cycle();
    sb_ready = 1'b0;
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL gap_single got=%b exp=0", sb_valid); end
    repeat (3) cycle();
  endtask

  task automatic test_overflow();
    int pulses;
    sb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_beat(32'hC000_0000 | k);
      send_beat(32'hD000_0000 | k);
      if (k < 4) exp_q.push_back({32'hD000_0000 | k, 32'hC000_0000 | k});
      if (k == 3) begin
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
      end
    end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    total++; if (sb_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", sb_valid); end
    sb_ready = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      total++; if (sb_data !== e) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", k, sb_data, e); end
      cycle();
      if (crd) pulses++;
    end
    sb_ready = 1'b0;
    repeat (5) begin
      cycle();
      if (crd) pulses++;
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL ovf_credits got=%0d exp=4", pulses); end
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", sb_valid); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
  endtask

  task automatic test_full_pop();
    logic [63:0] msg [5];
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    sb_ready = 1'b0;
    for (int k = 0; k < 5; k++) msg[k] = {32'hE000_0000 | k, 32'hF000_0000 | k};
    for (int k = 0; k < 4; k++) begin
      send_beat(msg[k][31:0]);
      send_beat(msg[k][63:32]);
    end
    send_beat(msg[4][31:0]);
    lp_valid = 1'b1;
    lp_cfg   = msg[4][63:32];
    sb_ready = 1'b1;
    cycle();
    lp_valid = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fp_ovf got=%b exp=0", ovf); end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (sb_valid !== 1'b1 || sb_data !== msg[k]) begin
        bad++; $display("FAIL fp_entry%0d got=%b/%h exp=1/%h", k, sb_valid, sb_data, msg[k]);
      end
      cycle();
    end
    sb_ready = 1'b0;
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", sb_valid); end
    repeat (8) cycle();
  endtask

  task automatic test_reset_mid();
    int pulses;
    sb_ready = 1'b0;
    send_beat(32'h0000_00A1); send_beat(32'h0000_00B1);
    send_beat(32'h0000_00A2); send_beat(32'h0000_00B2);
    send_beat(32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    total++;
    if (crd !== 1'b0 || sb_valid !== 1'b0 || sb_data !== 64'h0 || ovf !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL mid_rst got=%b/%b/%h/%b/%b exp=0/0/0/0/0", crd, sb_valid, sb_data, ovf, dbg_state);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      cycle();
      if (crd) pulses++;
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL mid_credits got=%0d exp=4", pulses); end
    send_beat(32'h0000_0011);
    send_beat(32'h0000_0022);
    total++;
    if (sb_valid !== 1'b1 || sb_data !== 64'h0000_0022_0000_0011) begin
      bad++; $display("FAIL mid_msg got=%b/%h exp=1/%h", sb_valid, sb_data, 64'h0000_0022_0000_0011);
    end
    sb_ready = 1'b1;
    cycle();
    sb_ready = 1'b0;
    total++; if (sb_valid !== 1'b0) begin bad++; $display("FAIL mid_only_one got=%b exp=0", sb_valid); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    lp_valid = 1'b0;
    lp_cfg   = '0;
    sb_ready = 1'b0;
    test_reset();
    test_two_beats();
    test_gap();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
